// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline latch with a skid register: in_ready comes from registered
// state only, so upstream never sees a combinational path from out_ready.
module pipe_skid_latch #(
    parameter int INSTR_W    = 12,
    parameter int ISET_W     = 4,
    parameter int PC_W       = 12,
    parameter int RESET_ISET = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ISET_W-1:0]  iset_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ISET_W-1:0]  iset_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [1:0]         occupancy
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               accept_s;
    logic               drain_s;
    logic               load_main_in_s;
    logic               load_main_skid_s;
    logic               load_skid_s;

    logic [INSTR_W-1:0] main_instr_r;
    logic [ISET_W-1:0]  main_iset_r;
    logic [PC_W-1:0]    main_pc_r;
    logic [INSTR_W-1:0] skid_instr_r;
    logic [ISET_W-1:0]  skid_iset_r;
    logic [PC_W-1:0]    skid_pc_r;

    assign accept_s  = in_valid && in_ready_r;
    assign drain_s   = out_valid_r && out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign occupancy = state_r;
    assign instr_out = main_instr_r;
    assign iset_out  = main_iset_r;
    assign pc_out    = main_pc_r;

    // Next-state and payload-steering decisions; flush wins over accept/drain.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && drain_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = FULL;
                        load_skid_s = 1'b1;
                    end else if (drain_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (drain_s) begin
                        state_nxt_s      = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State register plus the handshake outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != FULL);
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

    // Main payload: flush turns the presented instruction into a NOP, iset/pc hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_instr_r <= '0;
            main_iset_r  <= ISET_W'(RESET_ISET);
            main_pc_r    <= '0;
        end else if (flush) begin
            main_instr_r <= '0;
            main_iset_r  <= main_iset_r;
            main_pc_r    <= main_pc_r;
        end else if (load_main_in_s) begin
            main_instr_r <= instr_in;
            main_iset_r  <= iset_in;
            main_pc_r    <= pc_in;
        end else if (load_main_skid_s) begin
            main_instr_r <= skid_instr_r;
            main_iset_r  <= skid_iset_r;
            main_pc_r    <= skid_pc_r;
        end else begin
            main_instr_r <= main_instr_r;
            main_iset_r  <= main_iset_r;
            main_pc_r    <= main_pc_r;
        end
    end

    // Skid payload: captured only when the main entry is stalled and a second arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_instr_r <= '0;
            skid_iset_r  <= '0;
            skid_pc_r    <= '0;
        end else if (load_skid_s) begin
            skid_instr_r <= instr_in;
            skid_iset_r  <= iset_in;
            skid_pc_r    <= pc_in;
        end else begin
            skid_instr_r <= skid_instr_r;
            skid_iset_r  <= skid_iset_r;
            skid_pc_r    <= skid_pc_r;
        end
    end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Bench for pipe_skid_latch: directed vector table, queue-based reference model
// under random traffic, async-reset and wide-parameter corner cases.
module tb_pipe_skid_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [11:0] instr_in, pc_in, instr_out, pc_out;
    logic [3:0]  iset_in, iset_out;
    logic [1:0]  occupancy;

    logic        w_flush, w_in_valid, w_out_ready, w_in_ready, w_out_valid;
    logic [23:0] w_instr_in, w_instr_out;
    logic [3:0]  w_iset_in, w_iset_out;
    logic [15:0] w_pc_in, w_pc_out;
    logic [1:0]  w_occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_skid_latch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .iset_in(iset_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .iset_out(iset_out), .pc_out(pc_out),
        .occupancy(occupancy)
    );

    pipe_skid_latch #(.INSTR_W(24), .ISET_W(4), .PC_W(16), .RESET_ISET(3)) dut_w (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .instr_in(w_instr_in), .iset_in(w_iset_in), .pc_in(w_pc_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .instr_out(w_instr_out), .iset_out(w_iset_out), .pc_out(w_pc_out),
        .occupancy(w_occupancy)
    );

    typedef struct {
        logic [11:0] instr;
        logic [3:0]  iset;
        logic [11:0] pc;
    } ent_t;

    // Reference model: a FIFO of capacity two plus the last payload shown.
    ent_t q[$];
    ent_t shown;

    typedef struct {
        logic        fl, iv, ordy;
        logic [11:0] pc;
        logic        ev;
        logic [1:0]  eocc;
        logic        erdy;
        logic [11:0] epc;
        logic [11:0] einstr;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        shown = '{instr: 12'h000, iset: 4'h0, pc: 12'h000};
    endtask

    task automatic model_step();
        bit rdy;
        bit acc;
        bit drn;
        rdy = (q.size() != 2);
        acc = in_valid && rdy;
        drn = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
            shown.instr = 12'h000;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{instr: instr_in, iset: iset_in, pc: pc_in});
        end
        if (q.size() > 0) shown = q[0];
    endtask

    task automatic check_model();
        chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("m_occ", 32'(occupancy), 32'(q.size()));
        chk("m_ready", 32'(in_ready), 32'(q.size() != 2));
        chk("m_instr", 32'(instr_out), 32'(shown.instr));
        chk("m_iset", 32'(iset_out), 32'(shown.iset));
        chk("m_pc", 32'(pc_out), 32'(shown.pc));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy, input logic [11:0] pc);
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        pc_in     = pc;
        instr_in  = pc ^ 12'hA00;
        iset_in   = pc[3:0];
    endtask

    initial begin
        // fl iv ordy pc | ev occ rdy pc instr
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 2'd1, 1'b1, 12'h001, 12'hA01};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 2'd1, 1'b1, 12'h002, 12'hA02};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 12'h003, 1'b1, 2'd1, 1'b1, 12'h003, 12'hA03};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 12'h004, 1'b1, 2'd1, 1'b1, 12'h004, 12'hA04};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'h005, 1'b1, 2'd1, 1'b1, 12'h005, 12'hA05};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 2'd0, 1'b1, 12'h005, 12'hA05};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 12'h010, 1'b1, 2'd1, 1'b1, 12'h010, 12'hA10};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 12'h011, 1'b1, 2'd2, 1'b0, 12'h010, 12'hA10};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 12'h012, 1'b1, 2'd2, 1'b0, 12'h010, 12'hA10};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 2'd1, 1'b1, 12'h011, 12'hA11};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 2'd0, 1'b1, 12'h011, 12'hA11};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 12'h018, 1'b1, 2'd1, 1'b1, 12'h018, 12'hA18};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 12'h019, 1'b1, 2'd2, 1'b0, 12'h018, 12'hA18};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 12'h020, 1'b0, 2'd0, 1'b1, 12'h018, 12'h000};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 2'd0, 1'b1, 12'h018, 12'h000};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 12'h021, 1'b1, 2'd1, 1'b1, 12'h021, 12'hA21};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 2'd0, 1'b1, 12'h021, 12'hA21};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
        w_instr_in = 24'h0; w_iset_in = 4'h0; w_pc_in = 16'h0;
        model_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_instr", 32'(instr_out), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("w_rst_iset", 32'(w_iset_out), 32'd3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: streaming, backpressure, flush while full.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].pc);
            step();
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d_occ", i), 32'(occupancy), 32'(tbl[i].eocc));
            chk($sformatf("t%0d_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
            chk($sformatf("t%0d_pc", i), 32'(pc_out), 32'(tbl[i].epc));
            chk($sformatf("t%0d_instr", i), 32'(instr_out), 32'(tbl[i].einstr));
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
            instr_in  = 12'($urandom);
            iset_in   = 4'($urandom);
            pc_in     = 12'($urandom);
            step();
        end

        // Async reset while FULL, checked before any clock edge.
        drive(1'b0, 1'b1, 1'b0, 12'h030);
        step();
        drive(1'b0, 1'b1, 1'b0, 12'h031);
        step();
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_instr", 32'(instr_out), 32'd0);
        chk("arst_iset", 32'(iset_out), 32'd0);
        chk("arst_pc", 32'(pc_out), 32'd0);
        chk("w_arst_iset", 32'(w_iset_out), 32'd3);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 12'h040);
        step();
        chk("post_rst_pc", 32'(pc_out), 32'h040);

        // Wide-parameter pass-through.
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        w_in_valid = 1'b1; w_out_ready = 1'b1;
        w_instr_in = 24'hABCDEF; w_iset_in = 4'h9; w_pc_in = 16'hBEEF;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0; w_out_ready = 1'b0;
        chk("w_valid", 32'(w_out_valid), 32'd1);
        chk("w_instr", 32'(w_instr_out), 32'hABCDEF);
        chk("w_pc", 32'(w_pc_out), 32'hBEEF);
        chk("w_iset", 32'(w_iset_out), 32'h9);
        @(posedge clk);
        #1;
        chk("w_hold_pc", 32'(w_pc_out), 32'hBEEF);
        chk("w_hold_occ", 32'(w_occupancy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 SHALL have parameter INSTR_W, default 12, meaning instruction word width.
REQ-002 SHALL have parameter ISET_W, default 4, meaning instruction-set tag width.
REQ-003 SHALL have parameter PC_W, default 12, meaning program-counter width.
REQ-004 SHALL have parameter RESET_ISET, default 0 (base instruction set), meaning the reset value of iset_out.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-008 SHALL have port in_valid  input  1  upstream stage offers an entry.
REQ-009 SHALL have port in_ready  output  1  latch can accept an entry this cycle.
REQ-010 SHALL have ports instr_in, iset_in, pc_in  input  INSTR_W/ISET_W/PC_W  upstream payload.
REQ-011 SHALL have port out_valid  output  1  entry presented to downstream.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the entry this cycle.
REQ-013 SHALL have ports instr_out, iset_out, pc_out  output  INSTR_W/ISET_W/PC_W  presented payload.
REQ-014 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-015 SHALL hold two entries: a main register driving the out_* ports and a skid register; each entry is valid bit plus instr/iset/pc.
REQ-016 SHALL use occupancy as state: EMPTY(0), ONE(1, main valid), FULL(2, main and skid valid); skid SHALL never be valid while main is invalid.
REQ-017 SHALL drive in_ready = (occupancy != 2), from registered state only, with no combinational path from out_ready.
REQ-018 SHALL define accept = in_valid && in_ready, and drain = out_valid && out_ready.
REQ-019 In EMPTY, accept SHALL load the main register and go to ONE; latency input-to-out_valid is 1 cycle.
REQ-020 In ONE with accept and drain, SHALL load the main register from the input and stay in ONE.
REQ-021 In ONE with accept and no drain, SHALL load the skid register and go to FULL.
REQ-022 In ONE with drain only, SHALL go to EMPTY.
REQ-023 In FULL with drain, SHALL move skid into main and go to ONE; there is no accept because in_ready=0.
REQ-024 SHALL keep the out_* payload stable while out_valid=1 and out_ready=0.
REQ-025 SHALL preserve FIFO order; no entry is duplicated or dropped except by flush.
REQ-026 flush=1 SHALL clear both valid bits at the next edge (occupancy 0); it overrides accept and drain in that cycle, and the input offered in the flush cycle is discarded.
REQ-027 On flush, instr_out SHALL be set to 0 (NOP) and iset_out and pc_out SHALL hold their values.
REQ-028 When out_valid=0, the payload SHALL hold its last loaded value, except as set by flush or reset.
REQ-029 occupancy SHALL equal main_valid + skid_valid at all times.

Reset
REQ-030 While rst=1, SHALL force out_valid=0, occupancy=0, in_ready=1, instr_out=0, iset_out=RESET_ISET, pc_out=0, skid payload=0.
REQ-031 Reset SHALL abort any in-flight entries; the first edge after deassertion behaves as EMPTY.

Verification
REQ-032 Streaming with out_ready=1 and in_valid every cycle, pc 0x001..0x005 -> out_valid from cycle 1, pc_out 0x001..0x005 consecutively, occupancy stays 1.
REQ-033 Backpressure: out_ready=0, offer pc 0x010 then 0x011 -> occupancy 2, in_ready=0, pc_out holds 0x010; raise out_ready -> 0x010 then 0x011 emitted in order.
REQ-034 Flush in FULL with in_valid=1 (pc 0x020) -> next cycle occupancy 0, out_valid=0, instr_out=0; pc 0x020 is never emitted.
REQ-035 Async reset asserted mid-cycle while FULL -> outputs immediately at REQ-030 values, with no clock edge required.
REQ-036 Wide parameters INSTR_W=24, PC_W=16, RESET_ISET=3: pc 0xBEEF, instr 0xABCDEF pass through intact; iset_out=3 after reset.
